// File: rtl/prio_encoder_rr_parity_pkg.sv
// Shared constants and helpers for the parametrised priority encoder / parity checker.
package prio_enc_pkg;

  typedef enum logic [1:0] {
    MODE_MSB = 2'b00,
    MODE_LSB = 2'b01,
    MODE_RR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Width of the 1-based grant code, where 0 means no request.
  function automatic int code_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_parity_if.sv
// Request-in / result-out stream bundle for prio_encoder_rr_parity.
interface prio_encoder_rr_parity_if #(
    parameter int N    = 9,
    parameter int CNTW = 8
);
    localparam int CW = prio_enc_pkg::code_w(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_par;
    logic [1:0]    mode;
    logic          par_odd;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic [N-1:0]  out_grant;
    logic          out_par_ok;
    logic [CNTW-1:0] err_cnt;

    modport master (
        output in_valid, in_data, in_par, mode, par_odd, out_ready,
        input  in_ready, out_valid, out_code, out_grant, out_par_ok, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_par, mode, par_odd, out_ready,
        output in_ready, out_valid, out_code, out_grant, out_par_ok, err_cnt
    );
endinterface

// File: rtl/prio_find_first.sv
// Combinational first-set-bit finder: searches from a start index, upward or MSB-first.
module prio_find_first #(
    parameter int N = 9
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    input  logic                 msb_first,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [N-1:0] rot;

    always_comb begin
        int   j;
        int   k;
        int   pos;
        int   s;
        logic found;
        // NOTE: every output and temporary is assigned first, so no path can infer a latch.
        rot   = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        found = 1'b0;
        pos   = 0;

        // Rotate so that bit 'start' lands at position 0.
        for (int i = 0; i < N; i++) begin
            j = i + int'(start);
            if (j >= N) j = j - N;
            rot[i] = req[j];
        end

        for (int i = 0; i < N; i++) begin
            k = msb_first ? (N - 1 - i) : i;
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = k;
            end
        end

        s = pos + int'(start);
        if (s >= N) s = s - N;

        if (found) begin
            any      = 1'b1;
            idx      = IW'(s);
            grant[s] = 1'b1;
        end
    end
endmodule

// File: rtl/prio_encoder_rr_parity.sv
// Priority encoder (MSB/LSB/round-robin) with parity check, one-deep output stage
// with backpressure and a saturating parity-error counter.
module prio_encoder_rr_parity
    import prio_enc_pkg::*;
#(
    parameter int N    = 9,
    parameter int CNTW = 8
) (
    input logic                     clk,
    input logic                     rst,
    prio_encoder_rr_parity_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = code_w(N);

    mode_e          mode_s;
    logic           rr_sel;
    logic           msb_dir;
    logic           in_xfer;
    logic           any;
    logic           par_ok;
    logic [IW-1:0]  start;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  ptr;
    logic [N-1:0]   grant;
    logic [CW-1:0]  code_d;

    logic           out_valid_q;
    logic [CW-1:0]  out_code_q;
    logic [N-1:0]   out_grant_q;
    logic           out_par_ok_q;
    logic [CNTW-1:0] err_cnt_q;

    assign mode_s  = mode_e'(bus.mode);
    assign rr_sel  = (mode_s == MODE_RR);
    // The reserved encoding behaves as MSB-first.
    assign msb_dir = (mode_s == MODE_MSB) || (mode_s == MODE_RSV);
    assign start   = rr_sel ? ptr : '0;

    prio_find_first #(.N(N)) u_find (
        .req       (bus.in_data),
        .start     (start),
        .msb_first (msb_dir),
        .grant     (grant),
        .idx       (idx),
        .any       (any)
    );

    assign code_d  = any ? (CW'(idx) + CW'(1)) : '0;
    assign par_ok  = ((^bus.in_data) ^ bus.in_par) == bus.par_odd;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_code_q   <= '0;
            out_grant_q  <= '0;
            out_par_ok_q <= 1'b0;
            err_cnt_q    <= '0;
            ptr          <= '0;
        end else if (in_xfer) begin
            out_valid_q  <= 1'b1;
            out_code_q   <= code_d;
            out_grant_q  <= grant;
            out_par_ok_q <= par_ok;
            if (!par_ok && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNTW'(1);
            if (rr_sel && any) ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_code   = out_code_q;
    assign bus.out_grant  = out_grant_q;
    assign bus.out_par_ok = out_par_ok_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_prio_encoder_rr_parity.sv
// Directed, table-driven bench for prio_encoder_rr_parity (N=9, plus a CNTW=2 instance).
module tb_prio_encoder_rr_parity;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prio_encoder_rr_parity_if #(.N(9), .CNTW(8)) bus ();
    prio_encoder_rr_parity_if #(.N(9), .CNTW(2)) bus2 ();

    prio_encoder_rr_parity #(.N(9), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prio_encoder_rr_parity #(.N(9), .CNTW(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [1:0] mode;
        logic [8:0] data;
        logic       par;
        logic       par_odd;
        logic [3:0] exp_code;
        logic [8:0] exp_grant;
        logic       exp_ok;
        logic [7:0] exp_err;
    } vec_t;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [8:0] d,
                         input logic p, input logic po, input logic ordy);
        bus.in_valid  = v;
        bus.mode      = m;
        bus.in_data   = d;
        bus.in_par    = p;
        bus.par_odd   = po;
        bus.out_ready = ordy;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                             input logic [8:0] g, input logic ok, input logic [7:0] e);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".code"},  32'(bus.out_code),  32'(c));
        check({tag, ".grant"}, 32'(bus.out_grant), 32'(g));
        check({tag, ".par_ok"}, 32'(bus.out_par_ok), 32'(ok));
        check({tag, ".err"},   32'(bus.err_cnt),   32'(e));
    endtask

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{2'd0, 9'h0A6, 1'b1, 1'b0, 4'd8, 9'h080, 1'b0, 8'd1};
        vecs[1]  = '{2'd1, 9'h0A6, 1'b0, 1'b0, 4'd2, 9'h002, 1'b1, 8'd1};
        vecs[2]  = '{2'd2, 9'h111, 1'b1, 1'b0, 4'd1, 9'h001, 1'b1, 8'd1};
        vecs[3]  = '{2'd2, 9'h111, 1'b1, 1'b0, 4'd5, 9'h010, 1'b1, 8'd1};
        vecs[4]  = '{2'd2, 9'h111, 1'b0, 1'b1, 4'd9, 9'h100, 1'b1, 8'd1};
        vecs[5]  = '{2'd2, 9'h111, 1'b1, 1'b1, 4'd1, 9'h001, 1'b0, 8'd2};
        vecs[6]  = '{2'd2, 9'h000, 1'b0, 1'b0, 4'd0, 9'h000, 1'b1, 8'd2};
        vecs[7]  = '{2'd2, 9'h111, 1'b1, 1'b0, 4'd5, 9'h010, 1'b1, 8'd2};
        vecs[8]  = '{2'd0, 9'h003, 1'b0, 1'b0, 4'd2, 9'h002, 1'b1, 8'd2};
        vecs[9]  = '{2'd3, 9'h100, 1'b1, 1'b1, 4'd9, 9'h100, 1'b0, 8'd3};
        vecs[10] = '{2'd2, 9'h111, 1'b1, 1'b0, 4'd9, 9'h100, 1'b1, 8'd3};
        vecs[11] = '{2'd1, 9'h000, 1'b1, 1'b1, 4'd0, 9'h000, 1'b1, 8'd3};
        vecs[12] = '{2'd2, 9'h0A6, 1'b0, 1'b0, 4'd2, 9'h002, 1'b1, 8'd3};
        vecs[13] = '{2'd0, 9'h1FF, 1'b1, 1'b0, 4'd9, 9'h100, 1'b1, 8'd3};
        vecs[14] = '{2'd1, 9'h180, 1'b0, 1'b0, 4'd8, 9'h080, 1'b1, 8'd3};
        vecs[15] = '{2'd2, 9'h0A6, 1'b1, 1'b0, 4'd3, 9'h004, 1'b0, 8'd4};

        rst = 1'b1;
        drive(1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1);
        bus2.in_valid = 1'b0; bus2.mode = 2'd0; bus2.in_data = '0;
        bus2.in_par = 1'b0; bus2.par_odd = 1'b0; bus2.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_out("reset", 1'b0, 4'd0, 9'h000, 1'b0, 8'd0);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.err2", 32'(bus2.err_cnt), 32'd0);
        rst = 1'b0;

        // Full-throughput stream: one transfer per cycle, result checked one cycle later.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].data, vecs[i].par, vecs[i].par_odd, 1'b1);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_code, vecs[i].exp_grant,
                      vecs[i].exp_ok, vecs[i].exp_err);
        end

        // Stall three cycles; inputs change but the held result must not.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i), 9'h001, 1'(i), 1'(i + 1), 1'b0);
            #1;
            check($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            check_out($sformatf("stall%0d", i), 1'b1, 4'd3, 9'h004, 1'b0, 8'd4);
        end

        // Release: output and input transfer on the same edge.
        drive(1'b1, 2'd0, 9'h001, 1'b0, 1'b1, 1'b1);
        #1;
        check("release.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_out("b2b", 1'b1, 4'd1, 9'h001, 1'b1, 8'd4);

        // Drain with no new input.
        drive(1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("drain.valid", 32'(bus.out_valid), 32'd0);
        check("drain.in_ready", 32'(bus.in_ready), 32'd1);

        // Move ptr away from 0 (ptr=3 -> grant bit 4 -> ptr=5), then stall.
        drive(1'b1, 2'd2, 9'h111, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_out("pre_rst", 1'b1, 4'd5, 9'h010, 1'b1, 8'd4);

        // Reset mid-stall with an input offered: held result and offered word both dropped.
        rst = 1'b1;
        drive(1'b1, 2'd0, 9'h0FF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_out("mid_rst", 1'b0, 4'd0, 9'h000, 1'b0, 8'd0);
        check("mid_rst.in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("post_rst.valid", 32'(bus.out_valid), 32'd0);

        // ptr must be back at 0: round-robin grants bit 0, not bit 8.
        drive(1'b1, 2'd2, 9'h111, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_out("ptr_rst", 1'b1, 4'd1, 9'h001, 1'b1, 8'd0);
        drive(1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1);

        // Saturation on the 2-bit counter: parity-failing words only.
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1; bus2.mode = 2'd0; bus2.in_data = 9'h001;
            bus2.in_par = 1'b1; bus2.par_odd = 1'b1; bus2.out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("sat%0d.err", i), 32'(bus2.err_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            check($sformatf("sat%0d.ok", i), 32'(bus2.out_par_ok), 32'd0);
        end
        bus2.in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr_parity.md
# prio_encoder_rr_parity

Parametrised successor to the fixed 9-input priority encoder / parity checker. It accepts an N-bit request word plus a sideband parity bit over a valid/ready stream. It selects one request by MSB-first, LSB-first or round-robin priority, and checks the parity bit against the selected even/odd sense. Results are delivered through a one-deep registered output stage with backpressure, and a saturating parity-error count is kept. The block sits between the input pin mux and the display/decode logic.

## Interface
- `N`, 9: request width, 2..32.
- `CNTW`, 8: parity-error counter width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request word present.
- `in_ready`  out  1  block can accept this cycle.
- `in_data`  in  N  request bits; bit 0 is request 1.
- `in_par`  in  1  sideband parity bit for `in_data`.
- `mode`  in  2  00 MSB-first, 01 LSB-first, 10 round-robin, 11 treated as 00.
- `par_odd`  in  1  0: even parity expected over {in_data,in_par}; 1: odd.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_code`  out  $clog2(N+1)  1-based index of granted bit; 0 = no request.
- `out_grant`  out  N  one-hot grant; all-zero when no request.
- `out_par_ok`  out  1  parity check passed.
- `err_cnt`  out  CNTW  saturating count of accepted words with parity failure.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`, which gives full throughput.
- MSB-first: grant is the highest set bit.
- LSB-first: grant is the lowest set bit.
- Round-robin: search upward from pointer `ptr` (0..N-1), wrapping N-1 to 0. The first set bit found is granted.
- `ptr` update: on an input transfer in mode 10 with any bit set, `ptr <= (granted index + 1) mod N`. The index is 0-based, so the index N-1 grant wraps `ptr` to 0.
- `ptr` is unchanged by transfers in other modes and by all-zero words. It is retained across mode changes.
- Parity: `out_par_ok = (^{in_data,in_par}) == par_odd`, sampled at input transfer.
- `err_cnt`: +1 per input transfer with parity failure. It saturates at 2^CNTW-1 and never wraps.
- `mode` and `par_odd` are sampled only on input transfer. Changes while the output is stalled do not alter held results.

## Timing
- Latency 1 cycle: a transfer at edge k gives `out_valid`=1 with results after edge k.
- Output registers hold stable while `out_valid && !out_ready`.
- Simultaneous output transfer and new input transfer: the output register reloads and `out_valid` stays 1.
- Output transfer with no input transfer: `out_valid` goes to 0 next cycle.
- `err_cnt` updates on the same edge as the input transfer.
- Reset values: `out_valid`=0, `out_code`=0, `out_grant`=0, `out_par_ok`=0, `err_cnt`=0, `ptr`=0.
- After reset, `in_ready`=1.
- Reset mid-stream: a held result is discarded, and an input offered in the reset cycle is dropped.

## Structure
- Package `prio_enc_pkg`:
  - mode constants `MODE_MSB`=2'b00, `MODE_LSB`=2'b01, `MODE_RR`=2'b10;
  - function for `$clog2(N+1)` code width.
- Sub-module `prio_find_first`: combinational, parameter N.
  - Inputs: request vector, start index, direction.
  - Outputs: one-hot grant, 0-based index, any.
  - MSB and LSB modes use start index 0 with direction; round-robin uses rotate, find lowest, rotate back.
- Top holds the output register, `ptr`, `err_cnt` and the handshake.

## Test plan
- N=9, mode 00, `in_data`=9'h0A6, `in_par`=1, `par_odd`=0 → next cycle `out_code`=8, `out_grant`=9'h080, `out_par_ok`=0, `err_cnt`=1.
- Same word, mode 01, `in_par`=0 → `out_code`=2, `out_grant`=9'h002, `out_par_ok`=1, `err_cnt` unchanged.
- Mode 10, `in_data`=9'h111 held for 4 transfers from reset → codes 1,5,9,1.
  - `ptr` sequence 1,5,0,1; the 9→1 step checks wrap-around.
- `in_data`=0 → `out_code`=0, `out_grant`=0; in mode 10 `ptr` is unchanged.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable.
  - Then `out_ready`=1 with a new word → back-to-back transfer, `out_valid` stays 1.
- CNTW=2, 5 parity-failing transfers → `err_cnt` 1,2,3,3,3.
  - Assert `rst` mid-stall → `out_valid`=0, `err_cnt`=0, `ptr`=0 next cycle.
